// File: rtl/overflow_tracker_pkg.sv
// Shared types and width helpers for the overflow tracker slice.
package overflow_tracker_pkg;

  typedef enum logic {
    SNAP_IDLE,
    SNAP_HOLD
  } snap_state_t;

  localparam int EXT_W_DEFAULT = 12;

  // Composite snapshot width: extension bits plus the upstream low nibble.
  function automatic int COMP_W(input int ext);
    return ext + 4;
  endfunction

endpackage

// File: rtl/overflow_tracker_if.sv
// Bus between the overflow tracker and its upstream counter / downstream reader.
interface overflow_tracker_if import overflow_tracker_pkg::*; #(
  parameter int EXT_W = EXT_W_DEFAULT
);

  logic [3:0]               count_in;
  logic                     ovf_in;
  logic                     clear;
  logic [EXT_W-1:0]         thresh;
  logic                     irq;
  logic                     irq_ack;
  logic                     sat;
  logic [EXT_W-1:0]         ext_count;
  logic                     snap_req;
  logic                     snap_valid;
  logic                     snap_ready;
  logic [COMP_W(EXT_W)-1:0] snap_data;

  modport master (
    output count_in, ovf_in, clear, thresh, irq_ack, snap_req, snap_ready,
    input  irq, sat, ext_count, snap_valid, snap_data
  );

  modport slave (
    input  count_in, ovf_in, clear, thresh, irq_ack, snap_req, snap_ready,
    output irq, sat, ext_count, snap_valid, snap_data
  );

endinterface

// File: rtl/pulse_rise_det.sv
// Rising-edge detector: a level held high produces a single-cycle pulse.
module pulse_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/overflow_tracker.sv
// Extends an upstream 4-bit count with a saturating overflow counter,
// a sticky threshold interrupt and a valid/ready snapshot port.
module overflow_tracker import overflow_tracker_pkg::*; #(
  parameter int EXT_W = EXT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  overflow_tracker_if.slave bus
);

  localparam logic [EXT_W-1:0] EXT_MAX = '1;

  logic                     ovf_event;
  logic [EXT_W-1:0]         ext_q;
  logic [EXT_W-1:0]         ext_next;
  logic                     sat_q;
  logic                     sat_next;
  logic                     irq_q;
  logic                     irq_next;
  snap_state_t              state_q;
  snap_state_t              state_next;
  logic                     capture;
  logic [COMP_W(EXT_W)-1:0] snap_q;

  pulse_rise_det u_ovf_rise (
    .clk  (clk),
    .reset(reset),
    .d    (bus.ovf_in),
    .rise (ovf_event)
  );

  // irq fires only when the count itself moves onto the threshold, so a
  // threshold rewrite that happens to match the current count stays quiet.
  always_comb begin
    ext_next = ext_q;
    sat_next = sat_q;
    irq_next = irq_q;
    if (bus.clear) begin
      ext_next = '0;
      sat_next = 1'b0;
    end else if (ovf_event && (ext_q != EXT_MAX)) begin
      ext_next = ext_q + EXT_W'(1);
    end
    if (ext_next == EXT_MAX) begin
      sat_next = 1'b1;
    end
    if ((ext_next != ext_q) && (ext_next == bus.thresh) && (bus.thresh != '0)) begin
      irq_next = 1'b1;
    end else if (bus.irq_ack) begin
      irq_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_q <= '0;
      sat_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ext_q <= ext_next;
      sat_q <= sat_next;
      irq_q <= irq_next;
    end
  end

  // Requests arriving while a snapshot is held are dropped, which also
  // guarantees an idle cycle between consecutive snapshots.
  always_comb begin
    state_next = state_q;
    capture    = 1'b0;
    case (state_q)
      SNAP_IDLE: begin
        if (bus.snap_req) begin
          state_next = SNAP_HOLD;
          capture    = 1'b1;
        end
      end
      SNAP_HOLD: begin
        if (bus.snap_ready) begin
          state_next = SNAP_IDLE;
        end
      end
      default: state_next = SNAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SNAP_IDLE;
      snap_q  <= '0;
    end else begin
      state_q <= state_next;
      if (capture) begin
        snap_q <= {ext_q, bus.count_in};
      end
    end
  end

  assign bus.ext_count  = ext_q;
  assign bus.sat        = sat_q;
  assign bus.irq        = irq_q;
  assign bus.snap_valid = (state_q == SNAP_HOLD);
  assign bus.snap_data  = snap_q;

endmodule

// File: tb/tb_overflow_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level behavioural model, on a wide and a narrow tracker instance.
module tb_overflow_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  count_in = 4'd0;
  logic        ovf_in = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] thresh = 12'd0;
  logic        irq_ack = 1'b0;
  logic        snap_req = 1'b0;
  logic        snap_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    int   cnt;
    int   data;
    logic sat;
    logic irq;
    logic hold;
    logic prev_ovf;
  } model_t;

  model_t m [2];

  overflow_tracker_if #(.EXT_W(12)) bus0 ();
  overflow_tracker_if #(.EXT_W(4))  bus1 ();

  assign bus0.count_in   = count_in;
  assign bus0.ovf_in     = ovf_in;
  assign bus0.clear      = clear;
  assign bus0.thresh     = thresh;
  assign bus0.irq_ack    = irq_ack;
  assign bus0.snap_req   = snap_req;
  assign bus0.snap_ready = snap_ready;
  assign bus1.count_in   = count_in;
  assign bus1.ovf_in     = ovf_in;
  assign bus1.clear      = clear;
  assign bus1.thresh     = thresh[3:0];
  assign bus1.irq_ack    = irq_ack;
  assign bus1.snap_req   = snap_req;
  assign bus1.snap_ready = snap_ready;

  overflow_tracker #(.EXT_W(12)) dut_wide (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  overflow_tracker #(.EXT_W(4)) dut_narrow (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  // One clock of the tracker described in plain integer terms.
  function automatic model_t model_next(input model_t s, input int max);
    model_t n  = s;
    int     th = int'(thresh) & max;
    logic   ev = ovf_in && !s.prev_ovf;
    n.prev_ovf = ovf_in;
    if (clear) begin
      n.cnt = 0;
      n.sat = 1'b0;
    end else if (ev && s.cnt < max) begin
      n.cnt = s.cnt + 1;
    end
    if (n.cnt == max) n.sat = 1'b1;
    if (n.cnt != s.cnt && n.cnt == th && th != 0) n.irq = 1'b1;
    else if (irq_ack) n.irq = 1'b0;
    if (!s.hold) begin
      if (snap_req) begin
        n.hold = 1'b1;
        n.data = s.cnt * 16 + int'(count_in);
      end
    end else if (snap_ready) begin
      n.hold = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= model_next(m[0], 4095);
      m[1] <= model_next(m[1], 15);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int idx, input logic [31:0] ext,
                           input logic [31:0] sat, input logic [31:0] irq,
                           input logic [31:0] valid, input logic [31:0] data);
    check({tag, ".ext_count"}, ext, m[idx].cnt);
    check({tag, ".sat"}, sat, 32'(m[idx].sat));
    check({tag, ".irq"}, irq, 32'(m[idx].irq));
    check({tag, ".snap_valid"}, valid, 32'(m[idx].hold));
    if (m[idx].hold) check({tag, ".snap_data"}, data, m[idx].data);
  endtask

  task automatic check_output();
    check_dut("wide", 0, 32'(bus0.ext_count), 32'(bus0.sat), 32'(bus0.irq),
              32'(bus0.snap_valid), 32'(bus0.snap_data));
    check_dut("narrow", 1, 32'(bus1.ext_count), 32'(bus1.sat), 32'(bus1.irq),
              32'(bus1.snap_valid), 32'(bus1.snap_data));
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_output();
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      ovf_in = 1'b1;
      cycle();
      ovf_in = 1'b0;
      cycle();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic apply_stimulus();
    count_in   = 4'($urandom);
    ovf_in     = 1'($urandom);
    clear      = ($urandom_range(0, 31) == 0);
    irq_ack    = ($urandom_range(0, 7) == 0);
    snap_req   = ($urandom_range(0, 3) == 0);
    snap_ready = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 15) == 0) thresh = 12'($urandom_range(0, 20));
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) cycle();
    check("reset.ext_count", 32'(bus0.ext_count), 32'd0);
    check("reset.snap_valid", 32'(bus0.snap_valid), 32'd0);
    reset = 1'b1;
    cycle();

    // 40 isolated pulses; the narrow instance saturates on its 15th
    for (int i = 0; i < 40; i++) begin
      ovf_in = 1'b1;
      cycle();
      if (i == 13) check("narrow.sat_before_max", 32'(bus1.sat), 32'd0);
      if (i == 14) begin
        check("narrow.sat_at_max", 32'(bus1.sat), 32'd1);
        check("narrow.ext_at_max", 32'(bus1.ext_count), 32'd15);
      end
      ovf_in = 1'b0;
      cycle();
    end
    check("wide.ext_40", 32'(bus0.ext_count), 32'd40);
    check("wide.irq_40", 32'(bus0.irq), 32'd0);
    check("wide.sat_40", 32'(bus0.sat), 32'd0);
    check("narrow.ext_held", 32'(bus1.ext_count), 32'd15);

    // clear beats a coincident event; the held level then must not count
    clear  = 1'b1;
    ovf_in = 1'b1;
    cycle();
    clear = 1'b0;
    check("clear.wide_ext", 32'(bus0.ext_count), 32'd0);
    check("clear.narrow_sat", 32'(bus1.sat), 32'd0);
    cycle();
    check("clear.level_no_event", 32'(bus0.ext_count), 32'd0);
    ovf_in = 1'b0;
    cycle();

    ovf_in = 1'b1;
    repeat (10) cycle();
    ovf_in = 1'b0;
    cycle();
    ovf_in = 1'b1;
    repeat (3) cycle();
    ovf_in = 1'b0;
    cycle();
    check("level.ext_plus2", 32'(bus0.ext_count), 32'd2);

    do_clear();
    thresh = 12'd5;
    for (int i = 0; i < 5; i++) begin
      ovf_in = 1'b1;
      cycle();
      if (i == 3) check("irq.before_thresh", 32'(bus0.irq), 32'd0);
      if (i == 4) check("irq.at_thresh", 32'(bus0.irq), 32'd1);
      ovf_in = 1'b0;
      cycle();
    end
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    check("irq.ack_clears", 32'(bus0.irq), 32'd0);
    thresh = 12'd6;
    ovf_in = 1'b1;
    cycle();
    check("irq.rearm_6", 32'(bus0.irq), 32'd1);
    ovf_in  = 1'b0;
    irq_ack = 1'b1;
    cycle();
    thresh = 12'd7;
    ovf_in = 1'b1;
    cycle();
    check("irq.set_beats_ack", 32'(bus0.irq), 32'd1);
    ovf_in = 1'b0;
    cycle();
    irq_ack = 1'b0;
    thresh  = 12'd3;
    cycle();
    thresh = 12'd7;
    cycle();
    check("irq.thresh_change_only", 32'(bus0.irq), 32'd0);
    thresh = 12'd0;

    do_clear();
    pulse(3);
    count_in = 4'd9;
    snap_req = 1'b1;
    cycle();
    snap_req = 1'b0;
    check("snap.valid", 32'(bus0.snap_valid), 32'd1);
    check("snap.wide_data", 32'(bus0.snap_data), 32'h39);
    check("snap.narrow_data", 32'(bus1.snap_data), 32'h39);
    for (int i = 0; i < 4; i++) begin
      count_in = 4'(i);
      snap_req = (i == 1);
      cycle();
      check("snap.hold_valid", 32'(bus0.snap_valid), 32'd1);
      check("snap.hold_data", 32'(bus0.snap_data), 32'h39);
    end
    snap_ready = 1'b1;
    snap_req   = 1'b1;
    cycle();
    snap_ready = 1'b0;
    snap_req   = 1'b0;
    check("snap.released", 32'(bus0.snap_valid), 32'd0);
    cycle();

    do_clear();
    thresh = 12'd7;
    pulse(7);
    check("rst.pre_irq", 32'(bus0.irq), 32'd1);
    check("rst.pre_ext", 32'(bus0.ext_count), 32'd7);
    snap_req = 1'b1;
    cycle();
    snap_req = 1'b0;
    check("rst.pre_valid", 32'(bus0.snap_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst.async_ext", 32'(bus0.ext_count), 32'd0);
    check("rst.async_irq", 32'(bus0.irq), 32'd0);
    check("rst.async_sat", 32'(bus0.sat), 32'd0);
    check("rst.async_valid", 32'(bus0.snap_valid), 32'd0);
    check("rst.async_data", 32'(bus0.snap_data), 32'd0);
    check("rst.async_narrow_valid", 32'(bus1.snap_valid), 32'd0);
    cycle();
    reset  = 1'b1;
    thresh = 12'd0;
    cycle();

    for (int i = 0; i < 2000; i++) begin
      apply_stimulus();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/overflow_tracker.md
# overflow_tracker

Downstream companion to the 4-bit `first_counter`: consumes its `counter_out`/`overflow_out` and extends the count to a wide composite value. Every rising edge of the overflow signal increments a saturating extension counter. The block raises a sticky threshold interrupt with an acknowledge handshake. It also provides a coherent `{extension, low nibble}` snapshot through a valid/ready handshake to a register-read or logging stage.

## Interface
- `EXT_W`, 12, width of the overflow extension counter (composite width = `EXT_W`+4)
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset; clears all state
- `count_in`  in  4  `counter_out` of the upstream 4-bit counter
- `ovf_in`  in  1  `overflow_out` of the upstream counter; pulse or level
- `clear`  in  1  synchronous clear of extension count and saturation flag
- `thresh`  in  `EXT_W`  interrupt threshold; 0 disables interrupt
- `irq`  out  1  sticky threshold interrupt
- `irq_ack`  in  1  clears `irq`
- `sat`  out  1  sticky; extension counter has saturated
- `ext_count`  out  `EXT_W`  live extension count
- `snap_req`  in  1  single-cycle capture request
- `snap_valid`  out  1  snapshot held, awaiting consumer
- `snap_ready`  in  1  consumer accepts snapshot
- `snap_data`  out  `EXT_W`+4  captured `{ext_count, count_in}`

## Operation
- Edge detect: `ovf_q` registers `ovf_in`. An event is `ovf_in & ~ovf_q`. A level held high for N cycles counts once.
- Extension counter: an event increments `ext_count` by 1. At all-ones it holds its value and sets `sat`. No wrap.
- `clear`: `ext_count` is set to 0 and `sat` to 0. A coincident event is dropped. `ovf_q` still updates normally. `irq` is unaffected.
- Interrupt: `irq` is set on the edge where `ext_count` transitions to a value equal to `thresh`, with `thresh` ≠ 0. Equality caused by a change of `thresh` alone does not set `irq`. `irq_ack` clears `irq`. When set and ack occur in the same cycle, set wins.
- Snapshot FSM, two states:
  - IDLE: `snap_valid`=0. On `snap_req`, capture `{ext_count (pre-update register value), count_in}` into `snap_data` and go to HOLD.
  - HOLD: `snap_valid`=1, and `snap_data` stays stable. On `snap_ready`, go to IDLE. `snap_req` is ignored in HOLD, including in the cycle where `snap_ready` is sampled. No back-to-back capture; a minimum of one IDLE cycle between snapshots.
- Reset values: `ext_count`=0, `sat`=0, `irq`=0, `snap_valid`=0, `snap_data`=0, `ovf_q`=0, FSM=IDLE.
- Reset asserted mid-snapshot: `snap_valid` drops immediately (asynchronous). No handshake completion.

## Timing
- `ovf_in` sampled high at edge k with `ovf_q`=0: `ext_count` shows +1 after edge k. Latency 1 cycle.
- `irq` rises at the same edge as the matching `ext_count` update.
- `snap_req` sampled at edge k: `snap_valid`=1 and `snap_data` valid after edge k.
- Transfer occurs on any edge with `snap_valid & snap_ready`. `snap_valid` is low after that edge.
- `snap_ready` with `snap_valid`=0 has no effect.
- Inputs `count_in` and `ovf_in` are synchronous to `clk`. No synchronisers.
- Reset deassertion is assumed synchronised externally. The first active edge behaves as IDLE with all counts 0.

## Structure
- Package `overflow_tracker_pkg`:
  - `snap_state_t` enum {SNAP_IDLE, SNAP_HOLD}
  - `EXT_W_DEFAULT`=12
  - `COMP_W(ext)` = ext+4 width helper
- Sub-module `pulse_rise_det` (clk, reset, `d`, `rise`). It is reused for `ovf_in` and is the only natural split.
- Everything else lives in `overflow_tracker`: counter/saturation, irq logic, snapshot FSM.

## Test plan
- Reset then 40 single-cycle `ovf_in` pulses with `thresh`=0 -> `ext_count`=40, `irq`=0, `sat`=0.
- `ovf_in` held high 10 cycles, low 1, high 3 -> `ext_count` +2 only.
- `thresh`=5, 5 pulses -> `irq`=1 on the 5th update edge. `irq_ack` in the same cycle as a 5->5 non-event leaves `irq`=0. With `thresh`=6, a 6th pulse sets `irq` again.
- `EXT_W`=4, 17 pulses -> `ext_count`=15 and `sat`=1 after the 15th pulse. `clear` with a coincident pulse -> `ext_count`=0, `sat`=0.
- `count_in`=9, `ext_count`=3, `snap_req` -> `snap_data`=0x0039 (`EXT_W`=12), `snap_valid` held 4 cycles with `snap_ready`=0. A second `snap_req` during HOLD is ignored. `snap_ready` -> `snap_valid`=0 next edge.
- Assert `reset` low mid-HOLD with `ext_count`=7, `irq`=1 -> all outputs 0 immediately, before the next `clk` edge.
